sha256_msg_schedule: RTL

- Produces the SHA-256 message schedule W_0..W_63 for one 512-bit block, one 32-bit word per accepted handshake.
- It is the source end of the word stream that the sha256_round datapath consumes alongside its K constants; the round logic pulls words through a valid/ready interface.
- It keeps a 16-word sliding window and expands W_16..W_63 on the fly, so no 64-word memory is needed.
- It accepts a new block only when the previous block's schedule has fully drained.

---
 rtl/sha256_msg_schedule_if.sv | 23 ++
 rtl/sha256_msg_schedule.sv | 103 ++++++++++
 2 files changed

// File: rtl/sha256_msg_schedule_if.sv
// Handshake bundle between the SHA-256 message schedule and its neighbours:
// a 512-bit block input and a 32-bit word stream towards the round datapath.
interface sha256_msg_schedule_if;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         w_valid;
  logic         w_ready;
  logic [31:0]  w_data;
  logic [5:0]   w_index;
  logic         w_last;
  logic         busy;

  modport master (
    output blk_valid, blk_data, w_ready,
    input  blk_ready, w_valid, w_data, w_index, w_last, busy
  );

  modport slave (
    input  blk_valid, blk_data, w_ready,
    output blk_ready, w_valid, w_data, w_index, w_last, busy
  );
endinterface

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: a 16-word sliding window that streams W_0..W_{ROUNDS-1}
// of one block, expanding W_16 onwards as each word is accepted.
module sha256_msg_schedule #(
  parameter int ROUNDS = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sha256_msg_schedule_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [31:0] r_win [16];
  logic [5:0]  r_t;
  logic        w_blk_hs;
  logic        w_word_hs;
  logic        w_final;
  logic [31:0] w_expand;

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b00_0000_0000, x[31:10]};
  endfunction

  // Handshake decodes and the next expanded word
  always_comb begin
    w_blk_hs  = (r_state == IDLE) && bus.blk_valid;
    w_word_hs = (r_state == RUN) && bus.w_ready;
    w_final   = (r_t == LAST_T);
    w_expand  = sigma1(r_win[14]) + r_win[9] + sigma0(r_win[1]) + r_win[0];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (bus.blk_valid) begin
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        if (bus.w_ready && w_final) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Window load on block accept, shift-and-expand on each word accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        r_win[i] <= 32'h0000_0000;
      end
      r_t <= 6'd0;
    end else if (w_blk_hs) begin
      for (int i = 0; i < 16; i++) begin
        r_win[i] <= bus.blk_data[32*(15-i) +: 32];
      end
      r_t <= 6'd0;
    end else if (w_word_hs) begin
      for (int i = 0; i < 15; i++) begin
        r_win[i] <= r_win[i+1];
      end
      r_win[15] <= w_expand;
      // t returns to zero on the last word so w_index never exceeds ROUNDS-1
      r_t <= w_final ? 6'd0 : r_t + 6'd1;
    end
  end

  assign bus.blk_ready = (r_state == IDLE);
  assign bus.w_valid   = (r_state == RUN);
  assign bus.busy      = (r_state == RUN);
  assign bus.w_data    = r_win[0];
  assign bus.w_index   = r_t;
  assign bus.w_last    = (r_state == RUN) && w_final;

endmodule
